// File: rtl/ps2_event_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, decodes 11-bit frames,
// folds E0/F0 prefixes into one 10-bit event and queues events in a first-word-fall-through FIFO.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for a start bit (data=0 on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, accepting the byte
module ps2_event_receiver #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2Clk,
   input  logic                          ps2Data,
   output logic                          evtValid,
   output logic [9:0]                    evtData,
   input  logic                          evtReady,
   output logic [$clog2(FIFO_DEPTH):0]   evtCount,
   output logic [2:0]                    errFlags,
   input  logic                          errClr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall_edge;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          par_bit;
   logic          pend_ext, pend_brk;
   logic          push_req;
   logic [9:0]    push_data;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic          parity_ok;
   logic          stop_edge;
   logic          par_err, frm_err, ovf_err;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, push_ok;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1  <= ps2Clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2Data;
         data_s2 <= data_s1;
         if (clk_s2 != filt_clk) begin
            if (filt_cnt == FILT_LAST) begin
               filt_clk <= clk_s2;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   // The bit is taken in the same cycle the filtered clock is about to drop.
   assign fall_edge = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);
   assign timeout   = (state != S_IDLE) && (to_cnt == '0) && !fall_edge;
   assign parity_ok = ^{shift_reg, par_bit};
   assign stop_edge = fall_edge && (state == S_STOP);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         pend_ext  <= 1'b0;
         pend_brk  <= 1'b0;
         push_req  <= 1'b0;
         push_data <= '0;
         to_cnt    <= '0;
      end else begin
         push_req <= 1'b0;
         if (state == S_IDLE || fall_edge)
            to_cnt <= TO_LOAD;
         else if (to_cnt != '0)
            to_cnt <= to_cnt - TW'(1);

         if (timeout) begin
            state    <= S_IDLE;
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
         end else if (fall_edge) begin
            case (state)
               S_IDLE: begin
                  if (!data_s2) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shift_reg <= {data_s2, shift_reg[7:1]};
                  if (bit_cnt == 3'd7)
                     state <= S_PARITY;
                  else
                     bit_cnt <= bit_cnt + 3'd1;
               end
               S_PARITY: begin
                  par_bit <= data_s2;
                  state   <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if (data_s2 && parity_ok) begin
                     if (shift_reg == 8'hE0) begin
                        pend_ext <= 1'b1;
                     end else if (shift_reg == 8'hF0) begin
                        pend_brk <= 1'b1;
                     end else begin
                        push_req  <= 1'b1;
                        push_data <= {pend_ext, pend_brk, shift_reg};
                        pend_ext  <= 1'b0;
                        pend_brk  <= 1'b0;
                     end
                  end else begin
                     pend_ext <= 1'b0;
                     pend_brk <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign full     = (evtCount == FIFO_FULL);
   assign evtValid = (evtCount != '0);
   assign evtData  = mem[rd_ptr];
   assign pop      = evtValid && evtReady;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok  = push_req && (!full || pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         evtCount <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   evtCount <= evtCount + (AW+1)'(1);
            2'b01:   evtCount <= evtCount - (AW+1)'(1);
            default: evtCount <= evtCount;
         endcase
      end
   end

   assign par_err = stop_edge && !parity_ok;
   assign frm_err = (stop_edge && !data_s2) || timeout;
   assign ovf_err = push_req && full && !pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         errFlags <= '0;
      else if (errClr)
         errFlags <= {ovf_err, frm_err, par_err};
      else
         errFlags <= errFlags | {ovf_err, frm_err, par_err};
   end

endmodule

// File: tb/tb_ps2_event_receiver.sv
// Directed bench for ps2_event_receiver: drives PS/2 frames bit by bit and checks events,
// error flags and FIFO behaviour against hand-computed values.
module tb_ps2_event_receiver;

   localparam int DEPTH = 4;
   localparam int FLEN  = 4;
   localparam int TOUT  = 300;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          ps2Clk;
   logic          ps2Data;
   logic          evtValid;
   logic [9:0]    evtData;
   logic          evtReady;
   logic [CW-1:0] evtCount;
   logic [2:0]    errFlags;
   logic          errClr;

   int checks = 0;
   int errors = 0;

   ps2_event_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
      .clock(clock), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
      .evtValid(evtValid), .evtData(evtData), .evtReady(evtReady),
      .evtCount(evtCount), .errFlags(errFlags), .errClr(errClr)
   );

   always #5 clock = ~clock;

   // One PS/2 bit: 10 cycles high with data set up, 20 low, 10 high.
   task automatic send_bit(input logic b, input logic pop_at_push, input logic glitch);
      @(negedge clock) ps2Data = b;
      repeat (10) @(negedge clock);
      ps2Clk = 1'b0;
      if (pop_at_push) begin
         repeat (6) @(posedge clock);
         @(negedge clock) evtReady = 1'b1;
         @(negedge clock) evtReady = 1'b0;
         repeat (13) @(negedge clock);
      end else begin
         repeat (20) @(negedge clock);
      end
      ps2Clk = 1'b1;
      if (glitch) begin
         repeat (4) @(negedge clock);
         ps2Clk = 1'b0;
         @(negedge clock) ps2Clk = 1'b1;
         repeat (5) @(negedge clock);
      end else begin
         repeat (10) @(negedge clock);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input logic pop_at_push, input logic glitch);
      logic par;
      par = (~^b) ^ bad_par;
      send_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, glitch && (i == 3));
      send_bit(par, 1'b0, 1'b0);
      send_bit(~bad_stop, pop_at_push, 1'b0);
      ps2Data = 1'b1;
      repeat (5) @(negedge clock);
   endtask

   task automatic good_frame(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      @(negedge clock) evtReady = 1'b1;
      @(negedge clock) evtReady = 1'b0;
   endtask

   task automatic clear_errors();
      @(negedge clock) errClr = 1'b1;
      @(negedge clock) errClr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1; evtReady = 1'b0; errClr = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evtValid); end
      checks++; if (evtData !== 10'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", evtData); end
      checks++; if (evtCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", evtCount); end
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", errFlags); end
      reset = 1'b1;
      repeat (5) @(negedge clock);
   endtask

   task automatic test_single();
      good_frame(8'h1C);
      checks++; if (evtValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", evtValid); end
      checks++; if (evtData !== 10'h01C) begin errors++; $display("FAIL single_data: got %h expected 01c", evtData); end
      checks++; if (evtCount !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", evtCount); end
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL single_err: got %b expected 000", errFlags); end
      repeat (20) @(negedge clock);
      checks++; if (evtData !== 10'h01C) begin errors++; $display("FAIL single_hold: got %h expected 01c", evtData); end
      pop_one();
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", evtValid); end
      pop_one();
      checks++; if (evtCount !== 3'd0) begin errors++; $display("FAIL empty_pop: got %0d expected 0", evtCount); end
   endtask

   task automatic test_extended();
      good_frame(8'hE0);
      good_frame(8'hF0);
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL prefix_nopush: got %b expected 0", evtValid); end
      good_frame(8'h75);
      checks++; if (evtCount !== 3'd1) begin errors++; $display("FAIL ext_count: got %0d expected 1", evtCount); end
      checks++; if (evtData !== 10'h375) begin errors++; $display("FAIL ext_data: got %h expected 375", evtData); end
      pop_one();
      good_frame(8'h75);
      checks++; if (evtData !== 10'h075) begin errors++; $display("FAIL ext_cleared: got %h expected 075", evtData); end
      pop_one();
   endtask

   task automatic test_parity();
      good_frame(8'hE0);
      good_frame(8'hF0);
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL par_nopush: got %b expected 0", evtValid); end
      checks++; if (errFlags !== 3'b001) begin errors++; $display("FAIL par_err: got %b expected 001", errFlags); end
      clear_errors();
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL par_clr: got %b expected 000", errFlags); end
      good_frame(8'h1C);
      checks++; if (evtData !== 10'h01C) begin errors++; $display("FAIL par_pend_clear: got %h expected 01c", evtData); end
      pop_one();
   endtask

   task automatic test_frame_err();
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL stop_nopush: got %b expected 0", evtValid); end
      checks++; if (errFlags !== 3'b010) begin errors++; $display("FAIL stop_err: got %b expected 010", errFlags); end
      clear_errors();
   endtask

   task automatic test_timeout();
      send_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
      repeat (TOUT + 100) @(negedge clock);
      checks++; if (errFlags !== 3'b010) begin errors++; $display("FAIL timeout_err: got %b expected 010", errFlags); end
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL timeout_nopush: got %b expected 0", evtValid); end
      clear_errors();
      good_frame(8'h2A);
      checks++; if (evtData !== 10'h02A) begin errors++; $display("FAIL timeout_next: got %h expected 02a", evtData); end
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL timeout_next_err: got %b expected 000", errFlags); end
      pop_one();
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_q [4];
      good_frame(8'h11);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (evtCount !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", evtCount); end
      checks++; if (evtData !== 10'h022) begin errors++; $display("FAIL b2b_data: got %h expected 022", evtData); end
      good_frame(8'h33);
      good_frame(8'h44);
      good_frame(8'h55);
      send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (evtCount !== 3'd4) begin errors++; $display("FAIL full_pp_count: got %0d expected 4", evtCount); end
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL full_pp_err: got %b expected 000", errFlags); end
      exp_q = '{10'h033, 10'h044, 10'h055, 10'h066};
      for (int i = 0; i < 4; i++) begin
         checks++; if (evtData !== exp_q[i]) begin errors++; $display("FAIL full_pp_drain%0d: got %h expected %h", i, evtData, exp_q[i]); end
         pop_one();
      end
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL full_pp_empty: got %b expected 0", evtValid); end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      codes = '{8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E};
      for (int i = 0; i < 5; i++) good_frame(codes[i]);
      checks++; if (evtCount !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", evtCount); end
      checks++; if (errFlags !== 3'b100) begin errors++; $display("FAIL ovf_err: got %b expected 100", errFlags); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (evtData !== {2'b00, codes[i]}) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, evtData, {2'b00, codes[i]}); end
         pop_one();
      end
      checks++; if (evtCount !== 3'd0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", evtCount); end
      clear_errors();
   endtask

   task automatic test_glitch();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (evtData !== 10'h0A5) begin errors++; $display("FAIL glitch_data: got %h expected 0a5", evtData); end
      checks++; if (evtCount !== 3'd1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", evtCount); end
      checks++; if (errFlags !== 3'b000) begin errors++; $display("FAIL glitch_err: got %b expected 000", errFlags); end
      pop_one();
   endtask

   task automatic test_reset_midframe();
      good_frame(8'h66);
      good_frame(8'hE0);
      send_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
      @(negedge clock) reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (evtValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", evtValid); end
      checks++; if (evtCount !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", evtCount); end
      reset = 1'b1;
      repeat (5) @(negedge clock);
      good_frame(8'h5A);
      checks++; if (evtData !== 10'h05A) begin errors++; $display("FAIL rst_mid_next: got %h expected 05a", evtData); end
      checks++; if (evtCount !== 3'd1) begin errors++; $display("FAIL rst_mid_next_count: got %0d expected 1", evtCount); end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_single();
      test_extended();
      test_parity();
      test_frame_err();
      test_timeout();
      test_back_to_back();
      test_overflow();
      test_glitch();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
